// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported main memory between instruction fetch and the data path.
// Define ARB_RR_EN for round-robin arbitration; default is D priority with an IF starvation guard.
`timescale 1ns/1ps
module mem_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   // state | meaning
   // IDLE  | no access in flight, arbitrate pending requests
   // ISSUE | mem_en high for one cycle, latency count running
   // WAIT  | remaining memory latency, mem_rdata sampled at terminal count
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   localparam int LW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

   state_t            state_q, state_n;
   logic [LW-1:0]     lat_q, lat_n;
   logic              win_d_q, win_d_n;
   logic              store_q, store_n;
   logic              pick_d;
   logic              if_gnt_n, if_rvalid_n, d_gnt_n, d_rvalid_n;
   logic              mem_en_n, mem_we_n, busy_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [DATA_W-1:0] mem_wdata_n, if_rdata_n, d_rdata_n;

`ifdef ARB_RR_EN
   logic last_d_q, last_d_n;   // 0 = IF granted last, 1 = D granted last
   assign pick_d = d_req && (!if_req || !last_d_q);
`else
   localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
   logic [SW-1:0] starve_q, starve_n;
   assign pick_d = d_req && (!if_req || (starve_q != SW'(STARVE_MAX)));
`endif

   always_comb begin
      state_n     = state_q;
      lat_n       = lat_q;
      win_d_n     = win_d_q;
      store_n     = store_q;
      if_gnt_n    = 1'b0;
      d_gnt_n     = 1'b0;
      if_rvalid_n = 1'b0;
      d_rvalid_n  = 1'b0;
      mem_en_n    = 1'b0;
      mem_we_n    = 1'b0;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      if_rdata_n  = if_rdata;
      d_rdata_n   = d_rdata;
`ifdef ARB_RR_EN
      last_d_n    = last_d_q;
`else
      starve_n    = starve_q;
`endif
      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               state_n  = ISSUE;
               lat_n    = LW'(MEM_LAT);
               win_d_n  = pick_d;
               mem_en_n = 1'b1;
`ifdef ARB_RR_EN
               last_d_n = pick_d;
`endif
               if (pick_d) begin
                  d_gnt_n     = 1'b1;
                  store_n     = d_we;
                  mem_we_n    = d_we;
                  mem_addr_n  = d_addr;
                  mem_wdata_n = d_wdata;
`ifndef ARB_RR_EN
                  if (!if_req)
                     starve_n = '0;
                  else if (starve_q != SW'(STARVE_MAX))
                     starve_n = starve_q + 1'b1;
`endif
               end else begin
                  if_gnt_n   = 1'b1;
                  store_n    = 1'b0;
                  mem_addr_n = if_addr;
`ifndef ARB_RR_EN
                  starve_n   = '0;
`endif
               end
            end
         end
         ISSUE, WAIT: begin
            if (lat_q == LW'(1)) begin
               state_n = IDLE;
               lat_n   = '0;
               if (win_d_q) begin
                  d_rvalid_n = 1'b1;
                  if (!store_q)
                     d_rdata_n = mem_rdata;
               end else begin
                  if_rvalid_n = 1'b1;
                  if_rdata_n  = mem_rdata;
               end
            end else begin
               state_n = WAIT;
               lat_n   = lat_q - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         lat_q     <= '0;
         win_d_q   <= 1'b0;
         store_q   <= 1'b0;
         if_gnt    <= 1'b0;
         d_gnt     <= 1'b0;
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
`ifdef ARB_RR_EN
         last_d_q  <= 1'b0;
`else
         starve_q  <= '0;
`endif
      end else begin
         state_q   <= state_n;
         lat_q     <= lat_n;
         win_d_q   <= win_d_n;
         store_q   <= store_n;
         if_gnt    <= if_gnt_n;
         d_gnt     <= d_gnt_n;
         if_rvalid <= if_rvalid_n;
         d_rvalid  <= d_rvalid_n;
         if_rdata  <= if_rdata_n;
         d_rdata   <= d_rdata_n;
         mem_en    <= mem_en_n;
         mem_we    <= mem_we_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         busy      <= busy_n;
`ifdef ARB_RR_EN
         last_d_q  <= last_d_n;
`else
         starve_q  <= starve_n;
`endif
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_req, d_we;
   logic [7:0]  if_addr, d_addr;
   logic [15:0] d_wdata;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
   logic [15:0] if_rdata, d_rdata;
   logic        mem_en, mem_we, busy;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic [15:0] mem [256];

   int checks = 0;
   int errors = 0;

   mem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read of the held address, write on a strobed edge.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= {8'hA5, 8'(i)};
         mem[8'h10] <= 16'hBEEF;
      end else if (mem_en && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   typedef struct {
      logic        is_d;
      logic        we;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } vec_t;
   vec_t vecs [7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " gnt/rvalid"}, {28'd0, if_gnt, if_rvalid, d_gnt, d_rvalid}, 32'd0);
      chk({tag, " rdata"}, {if_rdata, d_rdata}, 32'd0);
      chk({tag, " mem ctl"}, {22'd0, mem_en, mem_we, mem_addr}, 32'd0);
      chk({tag, " mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
      chk({tag, " busy"}, {31'd0, busy}, 32'd0);
   endtask

   logic [1:0] exp_pat [6];

   initial begin
      vecs[0] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
      vecs[1] = '{1'b1, 1'b1, 8'h20, 16'h1234, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 8'h20, 16'h0000, 16'h1234};
      vecs[3] = '{1'b0, 1'b0, 8'h33, 16'h0000, 16'hA533};
      vecs[4] = '{1'b1, 1'b1, 8'h33, 16'h5A5A, 16'h1234};
      vecs[5] = '{1'b0, 1'b0, 8'h33, 16'h0000, 16'h5A5A};
      vecs[6] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 16'hA5FF};
`ifdef ARB_RR_EN
      exp_pat = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`endif

      rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;

      // Reset, then release with no requests
      step(); step();
      chk_all_zero("reset");
      rst_n = 1'b1;
      step();
      chk_all_zero("post-reset idle");

      // Lone fetch with held request: grant, data, next grant two edges later
      if_req = 1'b1; if_addr = 8'h10;
      step();
      chk("fetch gnt", {29'd0, if_gnt, d_gnt, mem_en}, 32'b101);
      chk("fetch addr", {24'd0, mem_addr}, 32'h10);
      chk("fetch busy", {31'd0, busy}, 32'd1);
      step();
      chk("fetch rvalid", {30'd0, if_rvalid, if_gnt}, 32'b10);
      chk("fetch rdata", {16'd0, if_rdata}, 32'hBEEF);
      chk("fetch busy clr", {31'd0, busy}, 32'd0);
      step();
      chk("fetch regrant", {31'd0, if_gnt}, 32'd1);
      if_req = 1'b0;
      step();
      step();

      // Single-requester transaction table
      for (int v = 0; v < 7; v++) begin
         if (vecs[v].is_d) begin
            d_req = 1'b1; d_we = vecs[v].we; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
         end else begin
            if_req = 1'b1; if_addr = vecs[v].addr;
         end
         step();
         chk($sformatf("vec%0d gnt", v), {30'd0, if_gnt, d_gnt}, {30'd0, !vecs[v].is_d, vecs[v].is_d});
         chk($sformatf("vec%0d mem_en/we", v), {30'd0, mem_en, mem_we}, {30'd0, 1'b1, vecs[v].we});
         chk($sformatf("vec%0d mem_addr", v), {24'd0, mem_addr}, {24'd0, vecs[v].addr});
         if (vecs[v].we)
            chk($sformatf("vec%0d mem_wdata", v), {16'd0, mem_wdata}, {16'd0, vecs[v].wdata});
         if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
         step();
         chk($sformatf("vec%0d rvalid", v), {30'd0, if_rvalid, d_rvalid}, {30'd0, !vecs[v].is_d, vecs[v].is_d});
         chk($sformatf("vec%0d rdata", v), {16'd0, vecs[v].is_d ? d_rdata : if_rdata}, {16'd0, vecs[v].exp_rdata});
         chk($sformatf("vec%0d idle", v), {30'd0, busy, mem_en}, 32'd0);
      end
      step();

      // Withdrawn fetch request during a data access
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
      step();
      chk("withdraw dgnt", {31'd0, d_gnt}, 32'd1);
      d_req = 1'b0; if_req = 1'b1; if_addr = 8'h44;
      step();
      if_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("withdraw no if_gnt %0d", k), {31'd0, if_gnt}, 32'd0);
      end

      // Reset while an access is in flight
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
      step();
      chk("midrst gnt", {31'd0, d_gnt}, 32'd1);
      d_req = 1'b0; rst_n = 1'b0;
      step();
      chk("midrst no rvalid", {30'd0, d_rvalid, if_rvalid}, 32'd0);
      chk("midrst busy", {30'd0, busy, mem_en}, 32'd0);
      rst_n = 1'b1; if_req = 1'b1; if_addr = 8'h10;
      step();
      chk("midrst next gnt", {31'd0, if_gnt}, 32'd1);
      if_req = 1'b0;
      step();
      chk("midrst next data", {15'd0, if_rvalid, if_rdata}, {15'd0, 1'b1, 16'hBEEF});

      // Both requesters held: arbitration sequence from a clean reset
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      if_req = 1'b1; if_addr = 8'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
      for (int g = 0; g < 6; g++) begin
         int n = 0;
         while (!(if_gnt || d_gnt) && n < 6) begin
            step();
            n++;
         end
         chk($sformatf("arb grant %0d", g), {30'd0, if_gnt, d_gnt}, {30'd0, exp_pat[g]});
         step();
      end
      if_req = 1'b0; d_req = 1'b0;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
